output_port_scheduler: RTL and testbench

OUTPUT_PORT_SCHEDULER -- requirements
Module: output_port_scheduler

---
 rtl/output_port_scheduler_pkg.sv | 14 +
 rtl/output_port_scheduler_port_rr_arbiter.sv | 127 ++++++++++++
 rtl/output_port_scheduler.sv | 69 ++++++
 tb/tb_output_port_scheduler.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/output_port_scheduler_pkg.sv
// Shared definitions for the output port scheduler.
//   PORT_NUB_TOTAL : default number of input ports and of output ports.
//   arb_state_e    : per-output arbiter state encoding.
package output_port_scheduler_pkg;

  localparam int unsigned PORT_NUB_TOTAL = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBusy  = 2'd1,
    StDrain = 2'd2
  } arb_state_e;

endpackage

// File: rtl/output_port_scheduler_port_rr_arbiter.sv
// Per-output-port arbiter: round-robin pick among candidate inputs, grant hold with a
// burst limit, and drain after a burst timeout until the owner lets go.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   vld_i          : valid per input port
//   cand_i         : inputs eligible for this output (valid, addressed here, not granted)
//   owner_dec_o    : one-hot owner while granting, else 0
//   timeout_dec_o  : one-cycle one-hot pulse when the grant is revoked by the burst limit
//   sel_o          : owner index while granting, else 0
//   sel_vld_o      : high while granting
module port_rr_arbiter
  import output_port_scheduler_pkg::*;
#(
  parameter int unsigned PORT_NUB  = PORT_NUB_TOTAL,
  parameter int unsigned WIDTH_SEL = $clog2(PORT_NUB),
  parameter int unsigned MAX_BURST = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PORT_NUB-1:0]  vld_i,
  input  logic [PORT_NUB-1:0]  cand_i,
  output logic [PORT_NUB-1:0]  owner_dec_o,
  output logic [PORT_NUB-1:0]  timeout_dec_o,
  output logic [WIDTH_SEL-1:0] sel_o,
  output logic                 sel_vld_o
);

  localparam int unsigned CntW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MAX_BURST - 1);
  localparam logic [WIDTH_SEL-1:0] LastInit = WIDTH_SEL'(PORT_NUB - 1);

  arb_state_e           st_q, st_d;
  logic [WIDTH_SEL-1:0] owner_q, owner_d;
  logic [WIDTH_SEL-1:0] last_q, last_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 to_q, to_d;

  logic                 pick_found;
  logic [WIDTH_SEL-1:0] pick_idx;
  logic [WIDTH_SEL:0]   scan_sum;

  // Scan from last_q+1 upwards with wrap. last_q < PORT_NUB and k <= PORT_NUB keep the
  // sum below 2*PORT_NUB, so a single conditional subtract implements the modulo.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_sum   = '0;
    for (int k = 1; k <= int'(PORT_NUB); k++) begin
      scan_sum = {1'b0, last_q} + (WIDTH_SEL + 1)'(k);
      if (scan_sum >= (WIDTH_SEL + 1)'(PORT_NUB)) begin
        scan_sum = scan_sum - (WIDTH_SEL + 1)'(PORT_NUB);
      end
      if (!pick_found && cand_i[scan_sum[WIDTH_SEL-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = scan_sum[WIDTH_SEL-1:0];
      end
    end
  end

  always_comb begin
    st_d    = st_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    unique case (st_q)
      StIdle: begin
        if (pick_found) begin
          owner_d = pick_idx;
          last_d  = pick_idx;
          cnt_d   = '0;
          st_d    = StBusy;
        end
      end
      StBusy: begin
        // A release in the last allowed cycle wins over the timeout.
        if (!vld_i[owner_q]) begin
          st_d = StIdle;
        end else if (cnt_q == CntLast) begin
          st_d = StDrain;
          to_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDrain: begin
        if (!vld_i[owner_q]) begin
          st_d = StIdle;
        end
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= StIdle;
      owner_q <= '0;
      last_q  <= LastInit;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      st_q    <= st_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    owner_dec_o   = '0;
    timeout_dec_o = '0;
    sel_o         = '0;
    sel_vld_o     = 1'b0;
    if (st_q == StBusy) begin
      owner_dec_o[owner_q] = 1'b1;
      sel_o                = owner_q;
      sel_vld_o            = 1'b1;
    end
    // owner_q is still held in the first drain cycle, when the pulse is visible.
    if (to_q) begin
      timeout_dec_o[owner_q] = 1'b1;
    end
  end

endmodule

// File: rtl/output_port_scheduler.sv
// Output port scheduler: one round-robin arbiter per output port, each granting one
// requesting input at a time with a bounded burst length.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   vld_in      : bit i = input i requesting / transferring
//   rx_in       : slice i = destination output port of input i
//   grant_out   : bit i = input i owns its destination output
//   sel_out     : slice o = input granted at output o (0 when none)
//   sel_vld_out : bit o = output o has a granted input
//   timeout_out : bit i pulses for one cycle when input i's grant hits the burst limit
module output_port_scheduler
  import output_port_scheduler_pkg::*;
#(
  parameter int unsigned PORT_NUB  = PORT_NUB_TOTAL,
  parameter int unsigned WIDTH_SEL = $clog2(PORT_NUB),
  parameter int unsigned MAX_BURST = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PORT_NUB-1:0]           vld_in,
  input  logic [PORT_NUB*WIDTH_SEL-1:0] rx_in,
  output logic [PORT_NUB-1:0]           grant_out,
  output logic [PORT_NUB*WIDTH_SEL-1:0] sel_out,
  output logic [PORT_NUB-1:0]           sel_vld_out,
  output logic [PORT_NUB-1:0]           timeout_out
);

  logic [PORT_NUB-1:0] owner_dec   [PORT_NUB];
  logic [PORT_NUB-1:0] timeout_dec [PORT_NUB];

  for (genvar o = 0; o < int'(PORT_NUB); o++) begin : g_out
    logic [PORT_NUB-1:0] cand;

    // Inputs already granted anywhere are excluded; out-of-range rx never matches.
    always_comb begin
      cand = '0;
      for (int i = 0; i < int'(PORT_NUB); i++) begin
        cand[i] = vld_in[i] && !grant_out[i] &&
                  (rx_in[i*WIDTH_SEL +: WIDTH_SEL] == WIDTH_SEL'(o));
      end
    end

    port_rr_arbiter #(
      .PORT_NUB  (PORT_NUB),
      .WIDTH_SEL (WIDTH_SEL),
      .MAX_BURST (MAX_BURST)
    ) u_arb (
      .clk           (clk),
      .rst           (rst),
      .vld_i         (vld_in),
      .cand_i        (cand),
      .owner_dec_o   (owner_dec[o]),
      .timeout_dec_o (timeout_dec[o]),
      .sel_o         (sel_out[o*WIDTH_SEL +: WIDTH_SEL]),
      .sel_vld_o     (sel_vld_out[o])
    );
  end

  // Transpose per-output owner decodes into per-input grant bits.
  always_comb begin
    grant_out   = '0;
    timeout_out = '0;
    for (int o = 0; o < int'(PORT_NUB); o++) begin
      grant_out   = grant_out | owner_dec[o];
      timeout_out = timeout_out | timeout_dec[o];
    end
  end

endmodule

// File: tb/tb_output_port_scheduler.sv
module tb_output_port_scheduler;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 2;
  localparam int unsigned MB = 8;

  logic           clk;
  logic           rst;
  logic [N-1:0]   vld_in;
  logic [N*W-1:0] rx_in;
  logic [N-1:0]   grant_out;
  logic [N*W-1:0] sel_out;
  logic [N-1:0]   sel_vld_out;
  logic [N-1:0]   timeout_out;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: per output, the current owner (-1 = free), whether the owner has
  // been cut off and is draining, grant cycles shown so far, and last winner.
  int           m_own   [N];
  bit           m_drain [N];
  int           m_held  [N];
  int           m_last  [N];
  logic [N-1:0] m_to;

  output_port_scheduler #(
    .PORT_NUB  (N),
    .WIDTH_SEL (W),
    .MAX_BURST (MB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .vld_in      (vld_in),
    .rx_in       (rx_in),
    .grant_out   (grant_out),
    .sel_out     (sel_out),
    .sel_vld_out (sel_vld_out),
    .timeout_out (timeout_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int dest_of(int i);
    return int'(rx_in[i*W +: W]);
  endfunction

  function automatic logic [N-1:0] m_grants();
    logic [N-1:0] g;
    g = '0;
    for (int o = 0; o < N; o++) begin
      if (m_own[o] >= 0 && !m_drain[o]) g[m_own[o]] = 1'b1;
    end
    return g;
  endfunction

  task automatic model_step();
    logic [N-1:0] busy;
    int           i;
    busy = m_grants();
    m_to = '0;
    if (rst) begin
      for (int o = 0; o < N; o++) begin
        m_own[o]   = -1;
        m_drain[o] = 1'b0;
        m_held[o]  = 0;
        m_last[o]  = N - 1;
      end
    end else begin
      for (int o = 0; o < N; o++) begin
        if (m_own[o] < 0) begin
          for (int k = 1; k <= N; k++) begin
            i = (m_last[o] + k) % N;
            if (m_own[o] < 0 && vld_in[i] && dest_of(i) == o && !busy[i]) begin
              m_own[o]   = i;
              m_last[o]  = i;
              m_held[o]  = 1;
              m_drain[o] = 1'b0;
            end
          end
        end else if (!m_drain[o]) begin
          if (!vld_in[m_own[o]]) begin
            m_own[o] = -1;
          end else if (m_held[o] == MB) begin
            m_drain[o]     = 1'b1;
            m_to[m_own[o]] = 1'b1;
          end else begin
            m_held[o]++;
          end
        end else if (!vld_in[m_own[o]]) begin
          m_own[o]   = -1;
          m_drain[o] = 1'b0;
        end
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [N-1:0]   ev;
    logic [N*W-1:0] es;
    ev = '0;
    es = '0;
    for (int o = 0; o < N; o++) begin
      if (m_own[o] >= 0 && !m_drain[o]) begin
        ev[o]         = 1'b1;
        es[o*W +: W]  = W'(m_own[o]);
      end
    end
    check_eq({tag, "/grant"},   32'(grant_out),   32'(m_grants()));
    check_eq({tag, "/sel_vld"}, 32'(sel_vld_out), 32'(ev));
    check_eq({tag, "/sel"},     32'(sel_out),     32'(es));
    check_eq({tag, "/timeout"}, 32'(timeout_out), 32'(m_to));
  endtask

  // Advance one clock: model follows the edge, outputs compared 1 time unit later.
  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_outputs(tag);
  endtask

  task automatic set_req(input int i, input logic v, input int dst);
    vld_in[i]        = v;
    rx_in[i*W +: W]  = W'(dst);
  endtask

  task automatic idle(input int n, input string tag);
    vld_in = '0;
    for (int c = 0; c < n; c++) tick(tag);
  endtask

  initial begin : main
    logic [N-1:0] prev;
    logic [N-1:0] eg;
    int           hold [N];
    int           order [$];
    int           gcnt;
    int           tcnt;

    rst    = 1'b1;
    vld_in = '0;
    rx_in  = '0;
    for (int o = 0; o < N; o++) begin
      m_own[o] = -1; m_drain[o] = 1'b0; m_held[o] = 0; m_last[o] = N - 1;
    end
    m_to = '0;
    #2;
    tick("reset");
    tick("reset");
    check_eq("reset_grant_zero", 32'(grant_out), 32'd0);
    rst = 1'b0;

    // Single request: input 0 to output 2.
    set_req(0, 1'b1, 2);
    tick("single");
    check_eq("single_grant", 32'(grant_out), 32'b0001);
    check_eq("single_sel_vld", 32'(sel_vld_out), 32'b0100);
    check_eq("single_sel2", 32'(sel_out[5:4]), 32'd0);
    idle(3, "single_idle");

    // Round robin among 0, 1, 3 on output 1, each holding 5 grant cycles.
    for (int i = 0; i < N; i++) hold[i] = 0;
    set_req(0, 1'b1, 1);
    set_req(1, 1'b1, 1);
    set_req(3, 1'b1, 1);
    prev = grant_out;
    for (int c = 0; c < 30; c++) begin
      tick("rr");
      for (int i = 0; i < N; i++) begin
        if (grant_out[i] && !prev[i]) order.push_back(i);
      end
      eg = m_grants();
      for (int i = 0; i < N; i++) begin
        if (eg[i]) begin
          hold[i]++;
          if (hold[i] == 5) vld_in[i] = 1'b0;
        end
      end
      prev = grant_out;
    end
    check_eq("rr_count", 32'(order.size()), 32'd3);
    check_eq("rr_first",  32'(order.size() > 0 ? order[0] : -1), 32'd0);
    check_eq("rr_second", 32'(order.size() > 1 ? order[1] : -1), 32'd1);
    check_eq("rr_third",  32'(order.size() > 2 ? order[2] : -1), 32'd3);
    idle(2, "rr_idle");

    // Burst limit: input 2 holds valid for 20 cycles on output 0.
    gcnt = 0;
    tcnt = 0;
    set_req(2, 1'b1, 0);
    for (int c = 0; c < 20; c++) begin
      tick("burst");
      if (grant_out[2]) gcnt++;
      if (timeout_out == 4'b0100) tcnt++;
    end
    check_eq("burst_grant_cycles", 32'(gcnt), 32'(MB));
    check_eq("burst_timeouts", 32'(tcnt), 32'd1);
    vld_in[2] = 1'b0;
    tick("burst_release");
    set_req(1, 1'b1, 0);
    tick("burst_reuse");
    check_eq("burst_reuse_grant", 32'(grant_out), 32'b0010);
    idle(3, "burst_idle");

    // Independent outputs granted on the same cycle.
    set_req(0, 1'b1, 0);
    set_req(1, 1'b1, 3);
    tick("par");
    check_eq("par_grant", 32'(grant_out), 32'b0011);
    check_eq("par_sel_vld", 32'(sel_vld_out), 32'b1001);
    idle(3, "par_idle");

    // Release in the last allowed cycle: no timeout, back to idle.
    set_req(3, 1'b1, 2);
    tick("edge");
    for (int c = 0; c < int'(MB) - 1; c++) tick("edge");
    vld_in[3] = 1'b0;
    tick("edge_release");
    check_eq("edge_no_timeout", 32'(timeout_out), 32'd0);
    check_eq("edge_grant_drop", 32'(grant_out), 32'd0);
    vld_in[3] = 1'b1;
    tick("edge_regrant");
    check_eq("edge_regrant", 32'(grant_out), 32'b1000);
    idle(3, "edge_idle");

    // Reset in the middle of a grant, then input 0 wins first.
    set_req(1, 1'b1, 0);
    tick("rst_busy");
    tick("rst_busy");
    tick("rst_busy");
    rst = 1'b1;
    tick("rst_abort");
    check_eq("rst_abort_grant", 32'(grant_out), 32'd0);
    check_eq("rst_abort_sel_vld", 32'(sel_vld_out), 32'd0);
    check_eq("rst_abort_sel", 32'(sel_out), 32'd0);
    check_eq("rst_abort_timeout", 32'(timeout_out), 32'd0);
    rst = 1'b0;
    set_req(0, 1'b1, 0);
    tick("rst_prio");
    check_eq("rst_prio_grant", 32'(grant_out), 32'b0001);
    idle(3, "rst_idle");

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 499) == 0);
      for (int i = 0; i < N; i++) begin
        if (vld_in[i]) begin
          if ($urandom_range(0, 7) == 0) vld_in[i] = 1'b0;
          if ($urandom_range(0, 15) == 0) rx_in[i*W +: W] = W'($urandom_range(0, N - 1));
        end else if ($urandom_range(0, 2) == 0) begin
          set_req(i, 1'b1, int'($urandom_range(0, N - 1)));
        end
      end
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
